lamp_fpu_div_post: RTL

//  Post-processing stage downstream of the iterative fractional divider in the BF16 FPU.

---
 rtl/lamp_fpu_div_post_if.sv | 36 +++
 rtl/lamp_fpu_div_post.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/lamp_fpu_div_post_if.sv
// Handshake bundle between the divider front-end, the iterative divider
// and the BF16 division post-processing stage.
interface lamp_fpu_div_post_if #(
  parameter int FRACT_DW = 7,
  parameter int EXP_DW   = 8
);
  localparam int Q_DW   = 2 * (1 + FRACT_DW);
  localparam int RES_DW = 1 + EXP_DW + FRACT_DW;

  logic                start_i;
  logic                ready_o;
  logic                sign_i;
  logic [EXP_DW+1:0]   exp_i;
  logic                special_i;
  logic [RES_DW-1:0]   special_res_i;
  logic                q_valid_i;
  logic [Q_DW-1:0]     q_i;
  logic                valid_o;
  logic                ready_i;
  logic [RES_DW-1:0]   res_o;
  logic                of_o;
  logic                uf_o;
  logic                nx_o;

  modport master (
    output start_i, sign_i, exp_i, special_i, special_res_i,
    output q_valid_i, q_i, ready_i,
    input  ready_o, valid_o, res_o, of_o, uf_o, nx_o
  );

  modport slave (
    input  start_i, sign_i, exp_i, special_i, special_res_i,
    input  q_valid_i, q_i, ready_i,
    output ready_o, valid_o, res_o, of_o, uf_o, nx_o
  );
endinterface

// File: rtl/lamp_fpu_div_post.sv
// BF16 division post-processing: waits for the divider quotient, then
// normalizes, rounds to nearest-even and packs the result.
module lamp_fpu_div_post #(
  parameter int FRACT_DW = 7,
  parameter int EXP_DW   = 8
) (
  input  logic clk,
  input  logic rst,
  lamp_fpu_div_post_if.slave bus
);
  localparam int Q_DW   = 2 * (1 + FRACT_DW);
  localparam int RES_DW = 1 + EXP_DW + FRACT_DW;
  localparam int MW     = FRACT_DW + 1;
  localparam int EW     = EXP_DW + 2;

  localparam logic signed [EW-1:0] ONE  = EW'(1);
  localparam logic signed [EW-1:0] ZERO = '0;
  localparam logic signed [EW-1:0] EMAX = EW'((2 ** EXP_DW) - 1);

  localparam logic [Q_DW-1:0] LO1 =
    (Q_DW'(1) << (Q_DW - 1 - MW)) - Q_DW'(1);
  localparam logic [Q_DW-1:0] LO2 =
    (Q_DW'(1) << (Q_DW - 2 - MW)) - Q_DW'(1);
  localparam logic [Q_DW-1:0] LO3 =
    (Q_DW'(1) << (Q_DW - 3 - MW)) - Q_DW'(1);

  typedef enum logic [2:0] {
    IDLE, WAIT_Q, NORM, RND, OUT
  } state_t;

  state_t state, state_nx;

  logic                 sign_r;
  logic signed [EW-1:0] exp_r;
  logic [Q_DW-1:0]      q_r;
  logic                 zero_r;
  logic [FRACT_DW-1:0]  m_r;
  logic                 g_r;
  logic                 s_r;
  logic signed [EW-1:0] e_r;
  logic [RES_DW-1:0]    res_r;
  logic                 of_r;
  logic                 uf_r;
  logic                 nx_r;

  logic [FRACT_DW-1:0]  m_n;
  logic                 g_n;
  logic                 s_n;
  logic signed [EW-1:0] e_n;

  logic                 up;
  logic                 carry;
  logic [FRACT_DW-1:0]  f_rd;
  logic signed [EW-1:0] e_rd;
  logic [RES_DW-1:0]    res_n;
  logic                 of_n;
  logic                 uf_n;
  logic                 nx_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (bus.start_i)
          state_nx = bus.special_i ? OUT : WAIT_Q;
      WAIT_Q:
        if (bus.q_valid_i) state_nx = NORM;
      NORM:    state_nx = RND;
      RND:     state_nx = OUT;
      OUT:
        if (bus.ready_i) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Hidden bit is implied by the selected leading one, so only the
  // stored fraction is kept.
  always_comb begin
    m_n = q_r[Q_DW-4 -: FRACT_DW];
    g_n = q_r[Q_DW-3-MW];
    s_n = |(q_r & LO3);
    e_n = exp_r - ONE;
    priority case (1'b1)
      q_r[Q_DW-1]: begin
        m_n = q_r[Q_DW-2 -: FRACT_DW];
        g_n = q_r[Q_DW-1-MW];
        s_n = |(q_r & LO1);
        e_n = exp_r + ONE;
      end
      q_r[Q_DW-2]: begin
        m_n = q_r[Q_DW-3 -: FRACT_DW];
        g_n = q_r[Q_DW-2-MW];
        s_n = |(q_r & LO2);
        e_n = exp_r;
      end
      default: ;
    endcase
  end

  // A fraction wrap to zero on round-up is exactly the 1.0 carry case.
  always_comb begin
    up    = g_r & (s_r | m_r[0]);
    carry = up & (&m_r);
    f_rd  = m_r + FRACT_DW'(up);
    e_rd  = carry ? e_r + ONE : e_r;
    res_n = {sign_r, e_rd[EXP_DW-1:0], f_rd};
    of_n  = 1'b0;
    uf_n  = 1'b0;
    nx_n  = g_r | s_r;
    if (zero_r) begin
      res_n = {sign_r, {(RES_DW-1){1'b0}}};
      uf_n  = 1'b1;
      nx_n  = 1'b0;
    end else if (e_rd >= EMAX) begin
      res_n = {sign_r, {EXP_DW{1'b1}}, {FRACT_DW{1'b0}}};
      of_n  = 1'b1;
      nx_n  = 1'b1;
    end else if (e_rd <= ZERO) begin
      res_n = {sign_r, {(RES_DW-1){1'b0}}};
      uf_n  = 1'b1;
      nx_n  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sign_r <= 1'b0;
      exp_r  <= '0;
      q_r    <= '0;
      zero_r <= 1'b0;
      m_r    <= '0;
      g_r    <= 1'b0;
      s_r    <= 1'b0;
      e_r    <= '0;
      res_r  <= '0;
      of_r   <= 1'b0;
      uf_r   <= 1'b0;
      nx_r   <= 1'b0;
    end else begin
      unique case (state)
        IDLE:
          if (bus.start_i) begin
            sign_r <= bus.sign_i;
            exp_r  <= bus.exp_i;
            if (bus.special_i) begin
              res_r <= bus.special_res_i;
              of_r  <= 1'b0;
              uf_r  <= 1'b0;
              nx_r  <= 1'b0;
            end
          end
        WAIT_Q:
          if (bus.q_valid_i) q_r <= bus.q_i;
        NORM: begin
          zero_r <= (q_r == '0);
          m_r    <= m_n;
          g_r    <= g_n;
          s_r    <= s_n;
          e_r    <= e_n;
        end
        RND: begin
          res_r <= res_n;
          of_r  <= of_n;
          uf_r  <= uf_n;
          nx_r  <= nx_n;
        end
        default: ;
      endcase
    end
  end

  assign bus.ready_o = (state == IDLE);
  assign bus.valid_o = (state == OUT);
  assign bus.res_o   = res_r;
  assign bus.of_o    = of_r;
  assign bus.uf_o    = uf_r;
  assign bus.nx_o    = nx_r;

endmodule
